cache_state_array: RTL and testbench
====================================

// Module: cache_state_array
// PURPOSE
// - Per-line, per-way valid (and optional dirty) state store for RVS192 L1/L2 caches.
// - Provides a combinational read port and a registered set/clear write port.
// - Contains a flash-invalidate sweep FSM that clears SWEEP_PER_CYC lines per cycle.
// - Sits beside the tag RAM and is driven by the cache controller; flush_busy stalls that controller.
// PARAMETERS
// - LINES          128  lines per way; power of 2, >= 2.
// - WAYS           4    associativity; power of 2, >= 2.
// - SWEEP_PER_CYC  4    lines cleared per sweep cycle; power of 2, divides LINES.
// PORTS
// - clk        in   1          clock.
// - rst_n      in   1          reset; asynchronous, active-low.
// - rd_index   in   IW         read line index, IW = $clog2(LINES).
// - rd_valid   out  WAYS       valid bits of line rd_index, combinational.
// - rd_dirty   out  WAYS       dirty bits of line rd_index, combinational.
// - wr_index   in   IW         write line index.
// - wr_way     in   $clog2(WAYS)  write way.
// - wr_set     in   1          set valid of (wr_index, wr_way).
// - wr_clear   in   1          clear valid (and dirty) of (wr_index, wr_way).
// - wr_dirty   in   1          with wr_set: also set dirty.
// - flush_req  in   1          start a flash invalidate; sampled in IDLE only.
// - flush_busy out  1          sweep in progress.
// - flush_done out  1          one-cycle pulse when the sweep completes.
// - wb_req     out  1          write-back request for a dirty entry.
// - wb_index   out  IW         line index of the dirty entry.
// - wb_way     out  $clog2(WAYS)  way of the dirty entry.
// - wb_ack     in   1          write-back accepted.
// BEHAVIOUR
// - Reset (async): all valid/dirty bits = 0; FSM = IDLE.
// - Reset values of outputs: flush_busy = 0, flush_done = 0, wb_req = 0, wb_index = 0, wb_way = 0.
// - Reset mid-sweep aborts the sweep immediately.
// - Read: rd_valid/rd_dirty are a pure function of the array.
//   - A write to the same index is visible on the next cycle; the same-cycle read returns the old value.
// - Write, updated on the clk edge:
//   - wr_set has priority over wr_clear.
//   - wr_set sets valid; it also sets dirty if wr_dirty = 1, otherwise leaves dirty unchanged.
//   - wr_clear clears both valid and dirty.
//   - All wr_* inputs are ignored while flush_busy = 1.
// - FSM states: IDLE, SWEEP, WB, DONE. ptr is a group counter, 0 .. LINES/SWEEP_PER_CYC-1.
// - IDLE: flush_req = 1 -> SWEEP, ptr = 0, flush_busy = 1 from the next cycle.
// - SWEEP: clear valid of all ways of lines ptr*SWEEP_PER_CYC .. +SWEEP_PER_CYC-1.
//   - ptr increments each cycle.
//   - At the last group -> DONE.
// - DONE: flush_done = 1 for one cycle, flush_busy = 0 -> IDLE.
//   - Total busy time = LINES/SWEEP_PER_CYC cycles.
// - flush_req while not IDLE: ignored; no queuing.
// - flush_req held high through DONE: re-samples in IDLE and starts a new sweep.
// CONFIGURATION
// - Macro DIRTY_TRACK_EN defined:
//   - Dirty storage present.
//   - In SWEEP, if the current group holds any valid & dirty entry -> WB; the group is not cleared that cycle.
//   - WB: wb_req = 1, with wb_index/wb_way set to the lowest (line, then way) dirty entry.
//   - wb_index/wb_way stay stable until wb_ack is sampled high.
//   - On ack: clear that dirty bit, drop wb_req -> SWEEP, which re-examines the same group.
//   - A group is cleared only when no dirty entries remain in it.
//   - wb_ack while wb_req = 0 is ignored.
// - Macro DIRTY_TRACK_EN undefined:
//   - No dirty storage; wr_dirty and wb_ack are ignored.
//   - rd_dirty = 0, wb_req = 0, wb_index = 0, wb_way = 0 at all times.
//   - WB state is never entered.
// TESTING
// - T1: release reset -> rd_valid = 4'b0000 for rd_index 0..127; flush_busy = 0, flush_done = 0.
// - T2: wr_set at idx 5, way 2 -> rd_valid(5) = 4'b0100 next cycle.
//   - wr_set + wr_clear at idx 5, way 0 -> 4'b0101 (set wins).
// - T3: fill all lines valid, pulse flush_req -> flush_busy high exactly 32 cycles.
//   - flush_done pulses once; all rd_valid = 0.
//   - wr_set to idx 9 during busy -> rd_valid(9) = 0 after done.
// - T4: assert rst_n = 0 at sweep cycle 10 -> flush_busy = 0 at once.
//   - Array all 0; flush_req after release starts from ptr 0.
// - T5 (DIRTY_TRACK_EN): dirty at (0,1) and (0,3); flush; wb_ack delayed 3 cycles ->
//   - wb_req (0,1) held 4 cycles, then (0,3);
//   - flush_done after 32 + 2 WB episodes;
//   - rd_dirty = 0 everywhere.
// - T6: flush_req pulsed at sweep cycle 5 -> ignored; exactly one flush_done.
//   - Without DIRTY_TRACK_EN, wr_dirty = 1 -> rd_dirty = 0, wb_req never asserts.

Source files
------------

// File: rtl/cache_state_array.sv
// Per-line, per-way valid/dirty state store with a flash-invalidate sweep FSM.
// Dirty storage and write-back handshaking are present only when DIRTY_TRACK_EN is defined.
module cache_state_array #(
    parameter int  LINES         = 128,
    parameter int  WAYS          = 4,
    parameter int  SWEEP_PER_CYC = 4,
    localparam int IW            = $clog2(LINES),
    localparam int WW            = $clog2(WAYS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IW-1:0]   rd_index,
    output logic [WAYS-1:0] rd_valid,
    output logic [WAYS-1:0] rd_dirty,
    input  logic [IW-1:0]   wr_index,
    input  logic [WW-1:0]   wr_way,
    input  logic            wr_set,
    input  logic            wr_clear,
    input  logic            wr_dirty,
    input  logic            flush_req,
    output logic            flush_busy,
    output logic            flush_done,
    output logic            wb_req,
    output logic [IW-1:0]   wb_index,
    output logic [WW-1:0]   wb_way,
    input  logic            wb_ack
);
    localparam int GROUPS = LINES / SWEEP_PER_CYC;
    localparam int PW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [PW-1:0] LAST_GRP = PW'(GROUPS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, WB = 2'd2, DONE = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [WAYS-1:0] valid_q [LINES];
    logic [WAYS-1:0] valid_d [LINES];
    logic            busy;
    logic            grp_dirty;
    logic            sweep_clr;
    logic [IW-1:0]   grp_base;

    assign busy      = (state_q == SWEEP) || (state_q == WB);
    assign grp_base  = IW'(ptr_q) * IW'(SWEEP_PER_CYC);
    assign sweep_clr = (state_q == SWEEP) && !grp_dirty;

`ifdef DIRTY_TRACK_EN
    logic [WAYS-1:0] dirty_q [LINES];
    logic [WAYS-1:0] dirty_d [LINES];
    logic [IW-1:0]   hit_line, wb_index_q, wb_index_d;
    logic [WW-1:0]   hit_way, wb_way_q, wb_way_d;
    logic            wb_fire;

    // Scan from the top down so the lowest (line, then way) dirty entry wins.
    always_comb begin
        grp_dirty = 1'b0;
        hit_line  = '0;
        hit_way   = '0;
        for (int k = SWEEP_PER_CYC - 1; k >= 0; k--) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (valid_q[grp_base + IW'(k)][w] && dirty_q[grp_base + IW'(k)][w]) begin
                    grp_dirty = 1'b1;
                    hit_line  = grp_base + IW'(k);
                    hit_way   = WW'(w);
                end
            end
        end
    end

    assign wb_fire = (state_q == WB) && wb_ack;
`else
    logic unused_wr_dirty;

    assign grp_dirty       = 1'b0;
    assign unused_wr_dirty = wr_dirty;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
`ifdef DIRTY_TRACK_EN
            wb_index_q <= '0;
            wb_way_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
`ifdef DIRTY_TRACK_EN
            wb_index_q <= wb_index_d;
            wb_way_q   <= wb_way_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
`ifdef DIRTY_TRACK_EN
        wb_index_d = wb_index_q;
        wb_way_d   = wb_way_q;
`endif
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                // A group holding dirty data is revisited after each write-back.
                if (grp_dirty) begin
                    state_d = WB;
`ifdef DIRTY_TRACK_EN
                    wb_index_d = hit_line;
                    wb_way_d   = hit_way;
`endif
                end else if (ptr_q == LAST_GRP) begin
                    state_d = DONE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PW'(1);
                end
            end
            WB: begin
                if (wb_ack) state_d = SWEEP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
`ifdef DIRTY_TRACK_EN
        dirty_d = dirty_q;
        if (wb_fire) dirty_d[wb_index_q][wb_way_q] = 1'b0;
`endif
        if (sweep_clr) begin
            for (int k = 0; k < SWEEP_PER_CYC; k++) begin
                valid_d[grp_base + IW'(k)] = '0;
`ifdef DIRTY_TRACK_EN
                dirty_d[grp_base + IW'(k)] = '0;
`endif
            end
        end
        if (!busy) begin
            if (wr_set) begin
                valid_d[wr_index][wr_way] = 1'b1;
`ifdef DIRTY_TRACK_EN
                if (wr_dirty) dirty_d[wr_index][wr_way] = 1'b1;
`endif
            end else if (wr_clear) begin
                valid_d[wr_index][wr_way] = 1'b0;
`ifdef DIRTY_TRACK_EN
                dirty_d[wr_index][wr_way] = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= '0;
`ifdef DIRTY_TRACK_EN
                dirty_q[i] <= '0;
`endif
            end
        end else begin
            valid_q <= valid_d;
`ifdef DIRTY_TRACK_EN
            dirty_q <= dirty_d;
`endif
        end
    end

    always_comb begin
        flush_busy = busy;
        flush_done = (state_q == DONE);
        rd_valid   = valid_q[rd_index];
`ifdef DIRTY_TRACK_EN
        rd_dirty = dirty_q[rd_index];
        wb_req   = (state_q == WB);
        wb_index = wb_index_q;
        wb_way   = wb_way_q;
`else
        rd_dirty = '0;
        wb_req   = 1'b0;
        wb_index = '0;
        wb_way   = '0;
`endif
    end

endmodule

// File: tb/tb_cache_state_array.sv
// Bench for cache_state_array: vector table, random traffic against an entry-level
// model, and flush sequences (busy length, write-back order, reset abort).
module tb_cache_state_array;
    localparam int LINES  = 128;
    localparam int WAYS   = 4;
    localparam int SPC    = 4;
    localparam int GROUPS = LINES / SPC;
    localparam int IW     = 7;
    localparam int WW     = 2;
`ifdef DIRTY_TRACK_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [IW-1:0]   rd_index;
    logic [WAYS-1:0] rd_valid;
    logic [WAYS-1:0] rd_dirty;
    logic [IW-1:0]   wr_index;
    logic [WW-1:0]   wr_way;
    logic            wr_set, wr_clear, wr_dirty, flush_req;
    logic            flush_busy, flush_done, wb_req;
    logic [IW-1:0]   wb_index;
    logic [WW-1:0]   wb_way;
    logic            wb_ack;

    always #5 clk = ~clk;

    cache_state_array #(.LINES(LINES), .WAYS(WAYS), .SWEEP_PER_CYC(SPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_index(rd_index), .rd_valid(rd_valid), .rd_dirty(rd_dirty),
        .wr_index(wr_index), .wr_way(wr_way), .wr_set(wr_set), .wr_clear(wr_clear),
        .wr_dirty(wr_dirty), .flush_req(flush_req), .flush_busy(flush_busy),
        .flush_done(flush_done), .wb_req(wb_req), .wb_index(wb_index), .wb_way(wb_way),
        .wb_ack(wb_ack)
    );

    int total = 0;
    int bad   = 0;
    bit mval   [LINES][WAYS];
    bit mdirty [LINES][WAYS];

    typedef struct {
        bit s, c, d;
        int idx, way;
        logic [3:0] old_v, new_v, new_d;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] m_rdv(input int idx);
        logic [3:0] r;
        for (int w = 0; w < WAYS; w++) r[w] = mval[idx][w];
        return r;
    endfunction

    function automatic logic [3:0] m_rdd(input int idx);
        logic [3:0] r;
        for (int w = 0; w < WAYS; w++) r[w] = mdirty[idx][w];
        return r;
    endfunction

    function automatic void m_write(input bit s, input bit c, input bit d, input int idx, input int way);
        if (s) begin
            mval[idx][way] = 1'b1;
            if (d && DT) mdirty[idx][way] = 1'b1;
        end else if (c) begin
            mval[idx][way]   = 1'b0;
            mdirty[idx][way] = 1'b0;
        end
    endfunction

    function automatic void m_clear();
        for (int l = 0; l < LINES; l++)
            for (int w = 0; w < WAYS; w++) begin
                mval[l][w]   = 1'b0;
                mdirty[l][w] = 1'b0;
            end
    endfunction

    task automatic drive_idle();
        wr_set = 0; wr_clear = 0; wr_dirty = 0; flush_req = 0; wb_ack = 0;
    endtask

    task automatic write(input bit s, input bit c, input bit d, input int idx, input int way);
        wr_set = s; wr_clear = c; wr_dirty = d;
        wr_index = IW'(idx); wr_way = WW'(way);
        cyc();
        m_write(s, c, d, idx, way);
        drive_idle();
    endtask

    task automatic check_all_zero(input string nm);
        for (int i = 0; i < LINES; i++) begin
            rd_index = IW'(i);
            #1;
            chk({nm, "_valid"}, rd_valid, 0);
            chk({nm, "_dirty"}, rd_dirty, 0);
        end
    endtask

    // Runs one flush from IDLE; write-backs are acked after ack_dly cycles of wb_req.
    task automatic do_flush(input int ack_dly, input int inject_at, input int set9_at, input string tag);
        int exp_l[$];
        int exp_w[$];
        int n_wb;
        int busy_cnt = 0, done_cnt = 0, run = 0, post = 0, i = 0;
        bit seen_done = 0;
        for (int l = 0; l < LINES; l++)
            for (int w = 0; w < WAYS; w++)
                if (DT && mval[l][w] && mdirty[l][w]) begin
                    exp_l.push_back(l);
                    exp_w.push_back(w);
                end
        n_wb = exp_l.size();
        chk({tag, "_busy_before"}, flush_busy, 0);
        flush_req = 1;
        wr_index = IW'(9); wr_way = WW'(1);
        cyc();
        flush_req = 0;
        while (i < 3000) begin
            flush_req = (i == inject_at);
            wr_set    = (i == set9_at);
            if (flush_busy) busy_cnt++;
            if (flush_done) begin
                done_cnt++;
                chk({tag, "_busy_at_done"}, flush_busy, 0);
            end
            if (wb_req) begin
                if (exp_l.size() == 0) chk({tag, "_wb_unexpected"}, wb_req, 0);
                else begin
                    chk({tag, "_wb_index"}, wb_index, exp_l[0]);
                    chk({tag, "_wb_way"}, wb_way, exp_w[0]);
                end
                run++;
                wb_ack = (run == ack_dly + 1);
            end else begin
                wb_ack = 0;
                if (run > 0) begin
                    chk({tag, "_wb_hold"}, run, ack_dly + 1);
                    if (exp_l.size() > 0) begin
                        void'(exp_l.pop_front());
                        void'(exp_w.pop_front());
                    end
                    run = 0;
                end
            end
            if (flush_done) seen_done = 1;
            else if (seen_done) post++;
            if (post == 3) break;
            cyc();
            i++;
        end
        drive_idle();
        chk({tag, "_finished"}, seen_done, 1);
        chk({tag, "_busy_cycles"}, busy_cnt, GROUPS + n_wb * (ack_dly + 2));
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_wb_remaining"}, exp_l.size(), 0);
        chk({tag, "_busy_after"}, flush_busy, 0);
        m_clear();
        check_all_zero({tag, "_after"});
        cyc();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int ridx, widx, way;
        bit s, c, d;
        drive_idle();
        rd_index = '0; wr_index = '0; wr_way = '0;
        rst_n = 0;
        m_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", flush_busy, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_wb_req", wb_req, 0);
        chk("rst_wb_index", wb_index, 0);
        chk("rst_wb_way", wb_way, 0);
        rst_n = 1;
        cyc();

        // T1
        check_all_zero("t1");
        chk("t1_busy", flush_busy, 0);
        chk("t1_done", flush_done, 0);
        cyc();

        // T2 and write-port rules
        tbl[0] = '{1, 0, 0,   5, 2, 4'b0000, 4'b0100, 4'b0000};
        tbl[1] = '{1, 1, 0,   5, 0, 4'b0100, 4'b0101, 4'b0000};
        tbl[2] = '{1, 0, 1,   5, 1, 4'b0101, 4'b0111, 4'b0010};
        tbl[3] = '{1, 0, 0,   5, 1, 4'b0111, 4'b0111, 4'b0010};
        tbl[4] = '{0, 1, 0,   5, 1, 4'b0111, 4'b0101, 4'b0000};
        tbl[5] = '{1, 1, 1, 127, 3, 4'b0000, 4'b1000, 4'b1000};
        tbl[6] = '{0, 1, 0, 127, 3, 4'b1000, 4'b0000, 4'b0000};
        tbl[7] = '{1, 0, 1,   0, 0, 4'b0000, 4'b0001, 4'b0001};
        for (int k = 0; k < 8; k++) begin
            wr_set = tbl[k].s; wr_clear = tbl[k].c; wr_dirty = tbl[k].d;
            wr_index = IW'(tbl[k].idx); wr_way = WW'(tbl[k].way);
            rd_index = IW'(tbl[k].idx);
            #1;
            chk("tbl_same_cycle_old", rd_valid, tbl[k].old_v);
            cyc();
            drive_idle();
            m_write(tbl[k].s, tbl[k].c, tbl[k].d, tbl[k].idx, tbl[k].way);
            chk("tbl_valid", rd_valid, tbl[k].new_v);
            chk("tbl_dirty", rd_dirty, DT ? tbl[k].new_d : 4'b0000);
        end

        // Random idle traffic against the model
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 2) == 0);
            d = $urandom_range(0, 1);
            widx = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, LINES - 1);
            way  = $urandom_range(0, WAYS - 1);
            ridx = $urandom_range(0, 1) ? widx : $urandom_range(0, LINES - 1);
            wr_set = s; wr_clear = c; wr_dirty = d;
            wr_index = IW'(widx); wr_way = WW'(way);
            rd_index = IW'(ridx);
            wb_ack = $urandom_range(0, 1);
            #1;
            chk("rnd_valid", rd_valid, m_rdv(ridx));
            chk("rnd_dirty", rd_dirty, m_rdd(ridx));
            chk("rnd_wb_req", wb_req, 0);
            chk("rnd_busy", flush_busy, 0);
            cyc();
            m_write(s, c, d, widx, way);
        end
        drive_idle();

        // T3 + T6: fill everything, flush with a stray flush_req and a write to line 9 mid-sweep
        for (int l = 0; l < LINES; l++)
            for (int w = 0; w < WAYS; w++) write(1, 0, 0, l, w);
        do_flush($urandom_range(0, 2), 5, 7, "t3");

        // T4: reset at sweep cycle 10
        for (int l = 0; l < 64; l++) write(1, 0, 0, l, l % WAYS);
        flush_req = 1;
        cyc();
        flush_req = 0;
        repeat (10) cyc();
        chk("t4_busy_mid", flush_busy, 1);
        rst_n = 0;
        #1;
        chk("t4_busy_abort", flush_busy, 0);
        chk("t4_done_abort", flush_done, 0);
        m_clear();
        check_all_zero("t4_array");
        cyc();
        rst_n = 1;
        cyc();
        for (int l = 0; l < LINES; l += 3) write(1, 0, 0, l, 2);
        do_flush(0, -1, -1, "t4_restart");

`ifdef DIRTY_TRACK_EN
        // T5
        write(1, 0, 1, 0, 1);
        write(1, 0, 1, 0, 3);
        rd_index = '0;
        #1;
        chk("t5_dirty_pre", rd_dirty, 4'b1010);
        do_flush(3, -1, -1, "t5");
`else
        // T6: dirty requests are ignored without dirty tracking
        write(1, 0, 1, 3, 2);
        rd_index = IW'(3);
        #1;
        chk("t6_valid", rd_valid, 4'b0100);
        chk("t6_dirty", rd_dirty, 4'b0000);
        do_flush(1, -1, -1, "t6");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
